// File: rtl/gf233_reduce_seq_if.sv
// Handshake bundle for gf233_reduce_seq: unreduced product in, reduced field element out.
interface gf233_reduce_seq_if #(
  parameter int unsigned M = 233
);
  logic           in_valid;
  logic           in_ready;
  logic [2*M-2:0] in_prod;
  logic           out_valid;
  logic           out_ready;
  logic [M-1:0]   out_res;

  modport master (
    output in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_res
  );

  modport slave (
    input  in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_res
  );
endinterface

// File: rtl/gf233_reduce_seq.sv
// Two-fold sequential reduction of a GF(2)[x] product modulo x^M + x^K + 1.
// Optional GF233_EARLY_EXIT_EN skips folds once the high part is already zero.
module gf233_reduce_seq #(
  parameter int unsigned M = 233,
  parameter int unsigned K = 74
) (
  input  logic               clk,
  input  logic               rst,
  gf233_reduce_seq_if.slave  bus,
  output logic               busy
);

  localparam int unsigned W = 2*M - 1;

  typedef enum logic [1:0] {IDLE, F1, F2, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [M-1:0]   out_res_q, out_res_d;
  logic           out_valid_q, out_valid_d;
  logic           busy_q, busy_d;
  logic           in_ready_c;
  logic           accept;
  logic [W-1:0]   fold_acc;

  // x^M == x^K + 1, so the high part h folds back as h ^ (h << K).
  function automatic logic [W-1:0] fold(input logic [W-1:0] a);
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    lo          = '0;
    lo[M-1:0]   = a[M-1:0];
    hi          = '0;
    hi[M-2:0]   = a[W-1:M];
    return lo ^ hi ^ (hi << K);
  endfunction

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    out_res_d   = out_res_q;
    out_valid_d = out_valid_q;
    fold_acc    = fold(acc_q);
    in_ready_c  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    accept      = bus.in_valid && in_ready_c;

    case (state_q)
      IDLE: ;
      F1: begin
        acc_d = fold_acc;
`ifdef GF233_EARLY_EXIT_EN
        if (fold_acc[W-1:M] == '0) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_res_d   = fold_acc[M-1:0];
        end else begin
          state_d = F2;
        end
`else
        state_d = F2;
`endif
      end
      F2: begin
        acc_d       = fold_acc;
        state_d     = DONE;
        out_valid_d = 1'b1;
        out_res_d   = fold_acc[M-1:0];
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
    endcase

    // A new accept overrides the DONE->IDLE return so handshakes chain with no bubble.
    if (accept) begin
      acc_d = bus.in_prod;
`ifdef GF233_EARLY_EXIT_EN
      if (bus.in_prod[W-1:M] == '0) begin
        state_d     = DONE;
        out_valid_d = 1'b1;
        out_res_d   = bus.in_prod[M-1:0];
      end else begin
        state_d     = F1;
        out_valid_d = 1'b0;
      end
`else
      state_d     = F1;
      out_valid_d = 1'b0;
`endif
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      out_res_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_res_q   <= out_res_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_res   = out_res_q;
  assign busy          = busy_q;

endmodule

// File: doc/gf233_reduce_seq.md
Name: gf233_reduce_seq

Overview:
- Sequential modular-reduction stage directly downstream of the 233-bit OBS multiplier's top-level overlap/recombination logic.
- Accepts the unreduced 465-bit GF(2)[x] product (degree ≤ 464) and reduces it modulo the trinomial x^233 + x^74 + 1 by iterative folding.
- Returns a 233-bit field element over a valid/ready handshake.
- Registering this stage breaks the long XOR path between product recombination and the consumer.

Parameters:
- M, 233, field degree; output width; input width is 2*M-1.
- K, 74, middle-term exponent of the trinomial; requires K < M/2 so two folds always suffice.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_prod valid
- in_ready  output  1  block can accept in_prod this cycle
- in_prod  input  2*M-1  unreduced product, bit i = coefficient of x^i
- out_valid  output  1  out_res valid
- out_ready  input  1  consumer accepts out_res
- out_res  output  M  reduced product, degree < M
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, active-high): state=IDLE, in_ready=1, out_valid=0, out_res=0, busy=0, internal accumulator acc (2*M-1 bits)=0. Reset mid-operation aborts the fold in progress; the result is discarded and never presented.
- Fold operation (combinational on acc): h = acc[2M-2:M]; fold(acc) = zero-extend(acc[M-1:0]) ^ zero-extend(h) ^ (zero-extend(h) << K).
  - Result after fold 1 has degree ≤ M-2+K.
  - Result after fold 2 has degree < M; acc[2M-2:M]=0 is guaranteed.
- FSM states: IDLE, F1, F2, DONE.
  - IDLE: in_ready=1. On in_valid: acc<=in_prod, go to F1.
  - F1: acc<=fold(acc), go to F2.
  - F2: acc<=fold(acc), go to DONE.
  - DONE: out_valid=1; out_res=acc[M-1:0], held stable while out_ready=0. On out_ready without a new accept, go to IDLE.
- Back-to-back: in_ready = (state==IDLE) || (state==DONE && out_ready). Simultaneous output handshake and input accept in DONE loads the new acc and goes to F1, giving zero bubble cycles between the handshakes.
- Latency: out_valid rises on the 3rd rising edge counting the accepting edge (accept, fold, fold). Throughput is one result per 3 cycles when out_ready is held high.
- in_prod is sampled only on the accepting edge; later changes are ignored. out_res changes only on edges entering DONE.
- in_ready is low in F1, F2, and in DONE while out_ready=0; no input is lost or overwritten.

Optional Feature:
- Macro GF233_EARLY_EXIT_EN.
- Defined:
  - On accept, if in_prod[2M-2:M]==0, acc<=in_prod and go directly to DONE (out_valid on the edge after accept).
  - In F1, if fold(acc)[2M-2:M]==0, go directly to DONE instead of F2.
  - Latency becomes 1 + number of folds needed (1, 2 or 3 edges); results are identical.
- Undefined: fixed 3-edge latency for every input.

Test Plan:
- in_prod = 1<<233 (x^233), out_ready=1 -> out_res has bits 74 and 0 set only; out_valid on 3rd edge after accept.
- in_prod = 1<<464 -> out_res bits {231,146,72} set only; latency 3 (also 3 with GF233_EARLY_EXIT_EN).
- in_prod = 0x20 (already reduced) -> out_res = 0x20; latency 3 without macro, 1 with GF233_EARLY_EXIT_EN.
- Backpressure: result pending, out_ready=0 for 5 cycles while in_valid=1 with new data -> out_valid and out_res stable, in_ready=0. Release out_ready -> new input accepted on the same edge as the handshake.
- Back-to-back: 4 products (x^233, x^464, x^300, all-ones 465-bit), out_ready=1 -> results in order, one every 3 cycles, matching the software reference x^300 -> bits {141,67}. Also compare all-ones against the software model.
- Assert rst while in F2 -> out_valid=0, in_ready=1 immediately. Next product reduces correctly with no stale output.
